// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: generic elastic pipeline register between two datapath
// stages. Carries an opaque payload plus halt tag over a valid/ready handshake,
// with flush-to-bubble, sticky halt freeze and a saturating stall counter.
// Optional feature macro: PIPEREG_SKID_EN adds a skid register (two entries,
// fully registered in_ready). Without it the stage holds one entry and in_ready
// looks through to out_ready combinationally.
module pipe_stage_elastic #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_halt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_halt,
  input  logic             flush,
  output logic             frozen,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Encoding doubles as the entry count so occupancy is a plain register read.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_data;
  logic             main_halt;
  logic             accept;
  logic             emit;

`ifdef PIPEREG_SKID_EN
  logic [WIDTH-1:0] skid_data;
  logic             skid_halt;
`endif

  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign emit      = out_valid & out_ready;
  assign accept    = in_valid & in_ready;

`ifdef PIPEREG_SKID_EN
  // Ready comes only from registered state, so no path from out_ready.
  assign in_ready = !frozen && (state != TWO);
`else
  // Single entry: room exists if empty or the head leaves this cycle.
  assign in_ready = !frozen && (!out_valid || out_ready);
`endif

  // Bubbles present NOP_VALUE and a clear halt tag to the next stage.
  assign out_data = out_valid ? main_data : NOP_VALUE;
  assign out_halt = out_valid & main_halt;

  // Entry storage and occupancy state; flush overrides any accept or emit.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= EMPTY;
      main_data <= NOP_VALUE;
      main_halt <= 1'b0;
`ifdef PIPEREG_SKID_EN
      skid_data <= NOP_VALUE;
      skid_halt <= 1'b0;
`endif
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            main_data <= in_data;
            main_halt <= in_halt;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_data <= in_data;
            main_halt <= in_halt;
`ifdef PIPEREG_SKID_EN
          end else if (accept) begin
            skid_data <= in_data;
            skid_halt <= in_halt;
            state     <= TWO;
`endif
          end else if (emit) begin
            state <= EMPTY;
          end
        end
`ifdef PIPEREG_SKID_EN
        TWO: begin
          if (emit) begin
            main_data <= skid_data;
            main_halt <= skid_halt;
            state     <= ONE;
          end
        end
`endif
        default: state <= EMPTY;
      endcase
    end
  end

  // Halt freeze: closes the input once a halt entry is taken, until flush.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      frozen <= 1'b0;
    end else if (flush) begin
      frozen <= 1'b0;
    end else if (accept && in_halt) begin
      frozen <= 1'b1;
    end
  end

  // Saturating count of cycles the head was blocked; flush leaves it alone.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: self-checking bench for pipe_stage_elastic. A queue
// model of the stage tracks expected outputs every cycle; a vector table and
// hand-written sequences cover streaming, backpressure, flush, halt,
// counter saturation and asynchronous reset.
`timescale 1ns/1ps
module tb_pipe_stage_elastic;

  localparam int               WIDTH     = 16;
  localparam logic [WIDTH-1:0] NOP       = 16'hDEAD;
  localparam int               CNT_W     = 4;
  localparam int               STALL_MAX = (1 << CNT_W) - 1;
`ifdef PIPEREG_SKID_EN
  localparam int CAP  = 2;
  localparam bit SKID = 1'b1;
`else
  localparam int CAP  = 1;
  localparam bit SKID = 1'b0;
`endif

  logic             CLK;
  logic             nRST;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_halt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_halt;
  logic             flush;
  logic             frozen;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  pipe_stage_elastic #(
    .WIDTH    (WIDTH),
    .NOP_VALUE(NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_halt  (in_halt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_halt (out_halt),
    .flush    (flush),
    .frozen   (frozen),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             halt;
  } entry_t;

  typedef struct {
    logic             iv;
    logic [WIDTH-1:0] d;
    logic             ordy;
    logic             exp_ov;
    logic [WIDTH-1:0] exp_data;
    logic [1:0]       exp_occ;
  } vec_t;

  entry_t           mq[$];
  bit               m_frozen;
  int               m_stall;
  bit               m_accept;
  logic [WIDTH-1:0] emitted[$];
  int               n_checks;
  int               n_fail;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Room in the stage as the queue model sees it.
  function automatic bit modelReady();
    if (m_frozen) return 1'b0;
    if (SKID) return (mq.size() < 2);
    return (mq.size() == 0) || out_ready;
  endfunction

  task automatic checkOutput();
    logic [WIDTH-1:0] exp_data;
    logic             exp_halt;
    exp_data = (mq.size() > 0) ? mq[0].data : NOP;
    exp_halt = (mq.size() > 0) ? mq[0].halt : 1'b0;
    compare("out_valid", out_valid, mq.size() > 0);
    compare("out_data",  out_data,  exp_data);
    compare("out_halt",  out_halt,  exp_halt);
    compare("in_ready",  in_ready,  modelReady());
    compare("frozen",    frozen,    m_frozen);
    compare("occupancy", occupancy, mq.size());
    compare("stall_cnt", stall_cnt, m_stall);
  endtask

  // Advance the queue model across the coming rising edge.
  task automatic modelStep();
    bit acc;
    bit emt;
    acc = in_valid && modelReady();
    emt = (mq.size() > 0) && out_ready;
    if (out_valid && out_ready) emitted.push_back(out_data);
    if ((mq.size() > 0) && !out_ready && (m_stall < STALL_MAX)) m_stall++;
    if (flush) begin
      mq.delete();
      m_frozen = 1'b0;
    end else begin
      if (emt) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{data: in_data, halt: in_halt});
        if (in_halt) m_frozen = 1'b1;
      end
    end
    m_accept = acc && !flush;
  endtask

  task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] d, input logic h,
                               input logic ordy, input logic fl);
    @(negedge CLK);
    in_valid  = iv;
    in_data   = d;
    in_halt   = h;
    out_ready = ordy;
    flush     = fl;
    #1;
    checkOutput();
    modelStep();
  endtask

  task automatic checkResetValues(input string tag);
    compare({tag, "_out_valid"}, out_valid, 1'b0);
    compare({tag, "_out_data"},  out_data,  NOP);
    compare({tag, "_out_halt"},  out_halt,  1'b0);
    compare({tag, "_in_ready"},  in_ready,  1'b1);
    compare({tag, "_frozen"},    frozen,    1'b0);
    compare({tag, "_occupancy"}, occupancy, 2'd0);
    compare({tag, "_stall_cnt"}, stall_cnt, '0);
  endtask

  task automatic clearModel();
    mq.delete();
    emitted.delete();
    m_frozen = 1'b0;
    m_stall  = 0;
    m_accept = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge CLK);
    in_valid  = 1'b0;
    in_data   = '0;
    in_halt   = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    nRST      = 1'b0;
    #1;
    checkResetValues("reset");
    clearModel();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t             vecs[6];
    logic [WIDTH-1:0] bp_items[3];
    int               k;
    int               maxocc;

    n_checks  = 0;
    n_fail    = 0;
    nRST      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_halt   = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    clearModel();

    vecs[0] = '{1'b1, 16'h0001, 1'b1, 1'b0, NOP,      2'd0};
    vecs[1] = '{1'b1, 16'h0002, 1'b1, 1'b1, 16'h0001, 2'd1};
    vecs[2] = '{1'b1, 16'h0003, 1'b1, 1'b1, 16'h0002, 2'd1};
    vecs[3] = '{1'b1, 16'h0004, 1'b1, 1'b1, 16'h0003, 2'd1};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 2'd1};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, NOP,      2'd0};

    $display("[TB] streaming table");
    applyReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].d, 1'b0, vecs[i].ordy, 1'b0);
      compare("tbl_out_valid", out_valid, vecs[i].exp_ov);
      compare("tbl_out_data",  out_data,  vecs[i].exp_data);
      compare("tbl_occupancy", occupancy, vecs[i].exp_occ);
      compare("tbl_in_ready",  in_ready,  1'b1);
      compare("tbl_stall_cnt", stall_cnt, '0);
    end

    $display("[TB] backpressure");
    applyReset();
    bp_items[0] = 16'h000A;
    bp_items[1] = 16'h000B;
    bp_items[2] = 16'h000C;
    k      = 0;
    maxocc = 0;
    for (int c = 0; c < 9; c++) begin
      if (k < 3) applyStimulus(1'b1, bp_items[k], 1'b0, c >= 4, 1'b0);
      else       applyStimulus(1'b0, '0, 1'b0, c >= 4, 1'b0);
      if (int'(occupancy) > maxocc) maxocc = int'(occupancy);
      if (m_accept) k++;
    end
    compare("bp_stall_cnt", stall_cnt, 3);
    compare("bp_max_occupancy", maxocc, CAP);
    compare("bp_emit_count", emitted.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < emitted.size()) compare("bp_emit_order", emitted[i], bp_items[i]);
    end

    $display("[TB] flush priority");
    applyReset();
    applyStimulus(1'b1, 16'h00A0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h00B0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0055, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    compare("flush_out_valid", out_valid, 1'b0);
    compare("flush_out_data",  out_data,  NOP);
    compare("flush_occupancy", occupancy, 2'd0);
    emitted.delete();
    applyStimulus(1'b1, 16'h0011, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0055, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    compare("flush2_out_valid", out_valid, 1'b0);
    repeat (3) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    compare("flush_emit_count", emitted.size(), 1);
    if (emitted.size() > 0) compare("flush_emit_data", emitted[0], 16'h0011);

    $display("[TB] halt freeze");
    applyReset();
    applyStimulus(1'b1, 16'h0007, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0009, 1'b0, 1'b1, 1'b0);
    compare("halt_frozen",   frozen,   1'b1);
    compare("halt_in_ready", in_ready, 1'b0);
    compare("halt_out_halt", out_halt, 1'b1);
    compare("halt_out_data", out_data, 16'h0007);
    applyStimulus(1'b1, 16'h0009, 1'b0, 1'b1, 1'b0);
    compare("halt_closed_out_valid", out_valid, 1'b0);
    applyStimulus(1'b1, 16'h0009, 1'b0, 1'b1, 1'b0);
    compare("halt_closed_out_valid2", out_valid, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 16'h0009, 1'b0, 1'b1, 1'b0);
    compare("halt_unfrozen",  frozen,   1'b0);
    compare("halt_reopened",  in_ready, 1'b1);

    $display("[TB] stall counter saturation");
    applyReset();
    applyStimulus(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    repeat (20) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    compare("sat_stall_cnt", stall_cnt, 15);
    compare("sat_out_valid", out_valid, 1'b1);

    $display("[TB] asynchronous reset mid-stream");
    applyReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, WIDTH'(16'h0100 + i), 1'b0, 1'b1, 1'b0);
    @(posedge CLK);
    #3;
    nRST = 1'b0;
    #1;
    checkResetValues("async");
    clearModel();
    @(negedge CLK);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    $display("[TB] randomized traffic");
    applyReset();
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom % 4) != 0, WIDTH'($urandom), ($urandom % 40) == 0,
                    ($urandom % 3) != 0, ($urandom % 25) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
